mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single data-memory port between the instruction-fetch stage and the MEM stage fed by the EX/MEM pipeline register.
- Sequences each access through a small FSM and handles variable-latency memory acknowledgements.
- Drives stall_if / stall_mem so the hazard logic freezes IF and EX/MEM while an access is outstanding.
- MEM has priority over IF, with an anti-starvation limit for fetch.

Parameters:
- WIDTH, `WIDTH (32): data and byte-address width.
- STARVE_LIMIT, 4: consecutive MEM grants, while IF is waiting, before IF is forced to win.
- TIMEOUT_CYCLES, 255: ack watchdog limit; used only with the optional feature.

Ports:
- clk  in  1: rising-edge clock.
- rst_n  in  1: asynchronous active-low reset.
- if_req  in  1: fetch request; held until if_valid.
- if_addr  in  WIDTH-2: fetch word address (program counter).
- if_rdata  out  WIDTH: fetched instruction.
- if_valid  out  1: one-cycle pulse, fetch complete.
- mem_req  in  1: MEM-stage request; held until mem_valid.
- mem_we  in  1: 1 = store, 0 = load.
- mem_addr  in  WIDTH: byte address from EX/MEM addr_out.
- mem_wdata  in  WIDTH: store data from EX/MEM dataC_out.
- mem_rdata  out  WIDTH: load data.
- mem_valid  out  1: one-cycle pulse, MEM access complete.
- ram_req  out  1: memory request.
- ram_we  out  1: memory write enable.
- ram_addr  out  WIDTH: memory byte address.
- ram_wdata  out  WIDTH: memory write data.
- ram_rdata  in  WIDTH: memory read data.
- ram_ack  in  1: memory completion; may coincide with the first ram_req cycle.
- stall_if  out  1: freeze fetch / PC.
- stall_mem  out  1: freeze EX/MEM and upstream stages.
- bus_err  out  1: timeout pulse (optional feature).

Behaviour:
- Reset (async, rst_n low): state IDLE. ram_req, ram_we, if_valid, mem_valid, bus_err = 0. ram_addr, ram_wdata, if_rdata, mem_rdata = 0. Starvation counter = 0. An in-flight memory access is abandoned with no completion pulse.
- States:
  - IDLE: if mem_req and (counter < STARVE_LIMIT or !if_req), go to BUSY_MEM. Else if if_req, go to BUSY_IF. Else stay in IDLE.
  - Grant actions: latch the address and data into the ram_* registers; set ram_req = 1 from the next cycle. For IF, ram_addr = {if_addr, 2'b00} and ram_we = 0. For MEM, ram_we = mem_we.
  - BUSY_x: hold all ram_* outputs stable. On ram_ack: capture ram_rdata into x_rdata (loads and fetches only; unchanged on stores), pulse x_valid the following cycle, drop ram_req, return to IDLE.
- Latency: request seen in cycle 0, ram_req in cycle 1, ack in cycle k >= 1, x_valid in cycle k+1. Zero-wait memory gives 2 cycles. A mandatory 1-cycle IDLE bubble separates back-to-back grants.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) on each MEM grant made while if_req = 1.
  - Clears on any IF grant.
  - Clears on a MEM grant with if_req = 0.
- Stalls (combinational): stall_if = if_req & ~if_valid; stall_mem = mem_req & ~mem_valid.
- ram_ack while in IDLE is ignored.
- Request inputs sampled in BUSY states are ignored until the FSM returns to IDLE.
- Requesters must keep their address and data stable while their req is high; the arbiter latches at grant anyway.

Optional Feature:
MEM_ARB_TIMEOUT_EN:
- Defined: a counter runs in BUSY states and clears on each grant. If TIMEOUT_CYCLES elapse with no ram_ack, the arbiter:
  - drops ram_req and returns to IDLE;
  - pulses x_valid together with bus_err for one cycle;
  - sets x_rdata = 0.
- Undefined: the arbiter waits indefinitely for ram_ack; bus_err is tied to 0 and no counter logic exists.

Test Plan:
- Reset mid-access: assert rst_n = 0 during BUSY_MEM -> ram_req = 0 immediately (async), no mem_valid pulse, IDLE after release.
- Zero-wait load: mem_req=1, mem_we=0, mem_addr=0x100, ram_ack tied high, ram_rdata=0xDEADBEEF -> ram_req in cycle 1, mem_valid with mem_rdata=0xDEADBEEF in cycle 2; stall_mem high in cycles 0-1 only.
- Wait states on store: mem_we=1, mem_wdata=0x12345678, ram_ack delayed 3 cycles -> ram_* stable throughout, mem_valid 1 cycle after ack, mem_rdata unchanged.
- Simultaneous requests: if_req and mem_req both held, if_addr=0x40 -> MEM grants first; after 4 MEM grants the IF access goes out with ram_addr=0x100; counter clears after that grant.
- Stray ack: ram_ack=1 in IDLE with no requests -> no state change, no valid pulses.
- With MEM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8: ram_ack never asserted -> mem_valid, bus_err and mem_rdata=0 pulse 8 cycles after ram_req rises, then IDLE.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shared data-memory port arbiter, MEM over IF with fetch anti-starvation
// Optional ack watchdog: define MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter #(
    parameter int WIDTH          = 32,
    parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             if_req,
    input  logic [WIDTH-3:0] if_addr,
    output logic [WIDTH-1:0] if_rdata,
    output logic             if_valid,
    input  logic             mem_req,
    input  logic             mem_we,
    input  logic [WIDTH-1:0] mem_addr,
    input  logic [WIDTH-1:0] mem_wdata,
    output logic [WIDTH-1:0] mem_rdata,
    output logic             mem_valid,
    output logic             ram_req,
    output logic             ram_we,
    output logic [WIDTH-1:0] ram_addr,
    output logic [WIDTH-1:0] ram_wdata,
    input  logic [WIDTH-1:0] ram_rdata,
    input  logic             ram_ack,
    output logic             stall_if,
    output logic             stall_mem,
    output logic             bus_err
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] SL = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_MEM} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    starve_q, starve_d;
    logic             ram_req_q, ram_req_d;
    logic             ram_we_q, ram_we_d;
    logic [WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [WIDTH-1:0] ram_wdata_q, ram_wdata_d;
    logic [WIDTH-1:0] if_rdata_q, if_rdata_d;
    logic [WIDTH-1:0] mem_rdata_q, mem_rdata_d;
    logic             if_valid_q, if_valid_d;
    logic             mem_valid_q, mem_valid_d;

    logic busy, pulse, grant_mem, grant_if, done, tmo_hit;

    // The completion-pulse cycle is the bubble: the finished requester still
    // holds its req there, so no grant is made until the pulse has gone.
    assign busy      = (state_q != IDLE);
    assign pulse     = if_valid_q | mem_valid_q;
    assign grant_mem = !busy && !pulse && mem_req && ((starve_q < SL) || !if_req);
    assign grant_if  = !busy && !pulse && !grant_mem && if_req;
    assign done      = busy && (ram_ack || tmo_hit);

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_q, tmo_d;
    logic          bus_err_q, bus_err_d;

    assign tmo_hit = busy && !ram_ack && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        tmo_d     = tmo_q;
        bus_err_d = tmo_hit;
        if (grant_mem || grant_if) tmo_d = '0;
        else if (busy)             tmo_d = tmo_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            tmo_q     <= tmo_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign bus_err = bus_err_q;
`else
    assign tmo_hit = 1'b0;
    assign bus_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            starve_q    <= '0;
            ram_req_q   <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            if_valid_q  <= 1'b0;
            mem_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            ram_req_q   <= ram_req_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            if_valid_q  <= if_valid_d;
            mem_valid_q <= mem_valid_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        unique case (state_q)
            IDLE: begin
                if (grant_mem) begin
                    state_d  = BUSY_MEM;
                    starve_d = !if_req ? '0 : ((starve_q == SL) ? starve_q : starve_q + 1'b1);
                end else if (grant_if) begin
                    state_d  = BUSY_IF;
                    starve_d = '0;
                end
            end
            BUSY_IF, BUSY_MEM: if (done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ram_req_d   = ram_req_q;
        ram_we_d    = ram_we_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        if_valid_d  = 1'b0;
        mem_valid_d = 1'b0;
        if (grant_mem) begin
            ram_req_d   = 1'b1;
            ram_we_d    = mem_we;
            ram_addr_d  = mem_addr;
            ram_wdata_d = mem_wdata;
        end else if (grant_if) begin
            ram_req_d  = 1'b1;
            ram_we_d   = 1'b0;
            ram_addr_d = {if_addr, 2'b00};
        end else if (done) begin
            ram_req_d = 1'b0;
            ram_we_d  = 1'b0;
            if (state_q == BUSY_IF) begin
                if_valid_d = 1'b1;
                if_rdata_d = tmo_hit ? '0 : ram_rdata;
            end else begin
                mem_valid_d = 1'b1;
                if (tmo_hit)        mem_rdata_d = '0;
                else if (!ram_we_q) mem_rdata_d = ram_rdata;
            end
        end
    end

    assign ram_req   = ram_req_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign mem_rdata = mem_rdata_q;
    assign if_valid  = if_valid_q;
    assign mem_valid = mem_valid_q;
    assign stall_if  = if_req & ~if_valid_q;
    assign stall_mem = mem_req & ~mem_valid_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter with a behavioural memory
module tb_mem_port_arbiter;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          if_req = 1'b0;
    logic [W-3:0]  if_addr = '0;
    logic [W-1:0]  if_rdata;
    logic          if_valid;
    logic          mem_req = 1'b0;
    logic          mem_we = 1'b0;
    logic [W-1:0]  mem_addr = '0;
    logic [W-1:0]  mem_wdata = '0;
    logic [W-1:0]  mem_rdata;
    logic          mem_valid;
    logic          ram_req;
    logic          ram_we;
    logic [W-1:0]  ram_addr;
    logic [W-1:0]  ram_wdata;
    logic [W-1:0]  ram_rdata = '0;
    logic          ram_ack = 1'b0;
    logic          stall_if;
    logic          stall_mem;
    logic          bus_err;

    always #5 clk = ~clk;

    mem_port_arbiter #(.WIDTH(W), .STARVE_LIMIT(4), .TIMEOUT_CYCLES(255)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_valid(mem_valid),
        .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .ram_ack(ram_ack),
        .stall_if(stall_if), .stall_mem(stall_mem), .bus_err(bus_err)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Memory behind the port and the bench's own reference copy
    logic [31:0] ram_mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction
    function automatic logic [31:0] ram_rd(input logic [31:0] a);
        return ram_mem.exists(a) ? ram_mem[a] : init_val(a);
    endfunction
    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    // Memory responder: ack after lat wait cycles, or tied high
    int lat = 0;
    bit ack_tie = 1'b0;
    bit rand_lat = 1'b0;
    int wcnt = 0;
    always @(negedge clk) begin
        if (!rst_n || !ram_req) wcnt = 0;
        if (rand_lat && ram_req && wcnt == 0) lat = $urandom_range(0, 4);
        ram_rdata = ram_rd(ram_addr);
        ram_ack   = ack_tie || (ram_req && wcnt >= lat);
        if (ram_req) begin
            if (ram_ack && ram_we) ram_mem[ram_addr] = ram_wdata;
            wcnt++;
        end
    end

    // Scoreboard monitor
    logic [31:0] exp_if [$];
    logic [31:0] exp_mem [$];
    bit          grant_log [$];
    logic [31:0] grant_addr [$];
    bit          prev_req = 1'b0;
    bit          prev_stall_if = 1'b0;
    int          streak = 0;
    logic [31:0] h_addr, h_wdata;
    logic        h_we;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_req = 1'b0;
            prev_stall_if = 1'b0;
            streak = 0;
        end else begin
            if (ram_req && !prev_req) begin
                grant_log.push_back(ram_addr < 32'h1000);
                grant_addr.push_back(ram_addr);
                if (ram_addr < 32'h1000) streak = 0;
                else if (prev_stall_if) streak++;
                else streak = 0;
                chk("starve_limit", 32'(streak <= 4), 32'd1);
                h_addr = ram_addr; h_wdata = ram_wdata; h_we = ram_we;
            end else if (ram_req && prev_req) begin
                chk("ram_stable", {ram_addr ^ h_addr} | {ram_wdata ^ h_wdata} | 32'(ram_we ^ h_we), 32'd0);
            end
            if (if_valid) begin
                if (exp_if.size() == 0) chk("if_valid_unexpected", 32'(if_valid), 32'd0);
                else chk("if_rdata", if_rdata, exp_if.pop_front());
                chk("bus_err", 32'(bus_err), 32'd0);
            end
            if (mem_valid) begin
                if (exp_mem.size() == 0) chk("mem_valid_unexpected", 32'(mem_valid), 32'd0);
                else chk("mem_rdata", mem_rdata, exp_mem.pop_front());
                chk("bus_err", 32'(bus_err), 32'd0);
            end
            prev_req = ram_req;
            prev_stall_if = stall_if;
        end
    end

    logic [31:0] last_load = '0;

    // Each task is entered just after a rising edge and returns just after one
    task automatic mem_txn(input bit we, input logic [31:0] a, input logic [31:0] d);
        int n;
        mem_we = we; mem_addr = a; mem_wdata = d; mem_req = 1'b1;
        if (we) ref_mem[a] = d;
        else    last_load = ref_rd(a);
        exp_mem.push_back(last_load);
        n = 0;
        do begin @(negedge clk); n++; end while (!mem_valid && n < 200);
        if (!mem_valid) chk("mem_wait_timeout", 32'(mem_valid), 32'd1);
        @(posedge clk); #1;
        mem_req = 1'b0;
    endtask

    task automatic if_txn(input logic [29:0] a);
        int n;
        logic [31:0] ba;
        ba = {a, 2'b00};
        if_addr = a; if_req = 1'b1;
        exp_if.push_back(ref_rd(ba));
        n = 0;
        do begin @(negedge clk); n++; end while (!if_valid && n < 200);
        if (!if_valid) chk("if_wait_timeout", 32'(if_valid), 32'd1);
        @(posedge clk); #1;
        if_req = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got running want finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        string seq;
        seq = "MMMMIMMMMIMM";

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ram_req", 32'(ram_req), 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_ram_addr", ram_addr, 32'd0);
        chk("rst_ram_wdata", ram_wdata, 32'd0);
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_mem_valid", 32'(mem_valid), 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_mem_rdata", mem_rdata, 32'd0);
        chk("rst_bus_err", 32'(bus_err), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        ram_mem[32'h100] = 32'hDEADBEEF;
        ref_mem[32'h100] = 32'hDEADBEEF;

        // Stray ack in IDLE
        ack_tie = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("stray_ram_req", 32'(ram_req), 32'd0);
            chk("stray_valid", 32'(mem_valid | if_valid), 32'd0);
        end

        // Zero-wait load with ack tied high
        @(posedge clk); #1;
        mem_we = 1'b0; mem_addr = 32'h100; mem_req = 1'b1;
        last_load = 32'hDEADBEEF;
        exp_mem.push_back(last_load);
        @(negedge clk);
        chk("zw_c0_ram_req", 32'(ram_req), 32'd0);
        chk("zw_c0_stall", 32'(stall_mem), 32'd1);
        @(negedge clk);
        chk("zw_c1_ram_req", 32'(ram_req), 32'd1);
        chk("zw_c1_addr", ram_addr, 32'h100);
        chk("zw_c1_stall", 32'(stall_mem), 32'd1);
        chk("zw_c1_valid", 32'(mem_valid), 32'd0);
        @(negedge clk);
        chk("zw_c2_valid", 32'(mem_valid), 32'd1);
        chk("zw_c2_stall", 32'(stall_mem), 32'd0);
        @(posedge clk); #1;
        mem_req = 1'b0;
        @(negedge clk);
        chk("zw_c3_valid", 32'(mem_valid), 32'd0);
        chk("zw_c3_ram_req", 32'(ram_req), 32'd0);
        ack_tie = 1'b0;

        // Store with three wait states
        lat = 3;
        @(posedge clk); #1;
        mem_we = 1'b1; mem_addr = 32'h1000; mem_wdata = 32'h12345678; mem_req = 1'b1;
        ref_mem[32'h1000] = 32'h12345678;
        exp_mem.push_back(last_load);
        n = 0;
        while (n < 50) begin
            @(negedge clk);
            if (mem_valid) break;
            n++;
        end
        chk("ws_valid_cycle", n, 32'd5);
        chk("ws_stall_at_valid", 32'(stall_mem), 32'd0);
        @(posedge clk); #1;
        mem_req = 1'b0;
        chk("ws_store_data", ram_rd(32'h1000), 32'h12345678);

        // Both requesters held: four MEM grants, then the fetch
        lat = 1;
        grant_log.delete();
        grant_addr.delete();
        @(posedge clk); #1;
        fork
            begin if_txn(30'h40); if_txn(30'h40); end
            begin
                for (int i = 0; i < 10; i++)
                    mem_txn(i[0], 32'h1000 + 32'(i) * 4, 32'hA0000000 + 32'(i));
            end
        join
        chk("starve_grant_cnt", grant_log.size(), 32'd12);
        for (int i = 0; i < 12; i++)
            if (i < grant_log.size()) chk("starve_grant_seq", 32'(grant_log[i]), 32'(seq[i] == "I"));
        if (grant_addr.size() > 4) chk("starve_if_addr", grant_addr[4], 32'h100);

        // Randomized traffic from both sides
        rand_lat = 1'b1;
        @(posedge clk); #1;
        fork
            begin
                for (int i = 0; i < 30; i++) begin
                    int g;
                    g = $urandom_range(0, 3);
                    if (g > 0) begin repeat (g) @(posedge clk); #1; end
                    if_txn(30'($urandom_range(0, 255)));
                end
            end
            begin
                for (int j = 0; j < 30; j++) begin
                    int g;
                    g = $urandom_range(0, 3);
                    if (g > 0) begin repeat (g) @(posedge clk); #1; end
                    mem_txn(1'($urandom_range(0, 1)), 32'h1000 + 32'($urandom_range(0, 63)) * 4, $urandom);
                end
            end
        join
        rand_lat = 1'b0;
        chk("rand_if_drained", exp_if.size(), 32'd0);
        chk("rand_mem_drained", exp_mem.size(), 32'd0);

        // Reset in the middle of a MEM access
        lat = 50;
        @(posedge clk); #1;
        mem_we = 1'b0; mem_addr = 32'h1004; mem_req = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!ram_req && n < 20);
        chk("mid_ram_req_up", 32'(ram_req), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_async_ram_req", 32'(ram_req), 32'd0);
        mem_req = 1'b0;
        last_load = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_ram_req", 32'(ram_req), 32'd0);
            chk("post_rst_mem_valid", 32'(mem_valid), 32'd0);
        end
        chk("post_rst_mem_rdata", mem_rdata, 32'd0);
        lat = 0;
        @(posedge clk); #1;
        mem_txn(1'b0, 32'h1008, 32'd0);
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
